// File: rtl/character_mover.sv
// character_mover
//   Moves one character a single tile on a tile map. A start request captures
//   the character, direction, sprite and current position, reads the target
//   tile, and either rejects the move (wall or map edge) or erases the old
//   tile, draws the sprite at the target and writes the new position back to
//   the external character register.
//
//   Configuration macro: CHAR_MOVER_WRAP_EN
//     defined   : moves off an edge wrap to the opposite edge
//     undefined : moves off an edge are rejected
//
//   Ports
//     clock, resetn        : clock, asynchronous active-low reset
//     start                : move request, sampled only while idle
//     char_sel, dir        : character index and direction (00 L, 01 R, 10 U, 11 D)
//     sprite_in            : tile code drawn at the new position
//     x_read, y_read       : current position of char_sel
//     map_data_in          : map read data, valid the cycle after map_read
//     map_address          : map read/write address
//     map_read, map_write  : map strobes
//     map_data_out         : map write data
//     x_write, y_write     : new position
//     char_sel_out         : character being updated
//     char_reg_write       : character register write strobe
//     busy, done, blocked  : status; blocked qualifies done
module character_mover #(
    parameter int         MAP_W     = 21,
    parameter int         MAP_H     = 21,
    parameter int         COORD_W   = 8,
    parameter int         ADDR_W    = 9,
    parameter int         NUM_CHARS = 4,
    parameter logic [2:0] WALL_TILE = 3'd1,
    localparam int        CSEL_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    input  logic [CSEL_W-1:0]  char_sel,
    input  logic [1:0]         dir,
    input  logic [2:0]         sprite_in,
    input  logic [COORD_W-1:0] x_read,
    input  logic [COORD_W-1:0] y_read,
    input  logic [2:0]         map_data_in,
    output logic [ADDR_W-1:0]  map_address,
    output logic               map_read,
    output logic               map_write,
    output logic [2:0]         map_data_out,
    output logic [COORD_W-1:0] x_write,
    output logic [COORD_W-1:0] y_write,
    output logic [CSEL_W-1:0]  char_sel_out,
    output logic               char_reg_write,
    output logic               busy,
    output logic               done,
    output logic               blocked
);

    typedef enum logic [2:0] {IDLE, CALC, RD, CHK, ERASE, DRAW, UPD, FIN} state_t;

    localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(MAP_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(MAP_H - 1);
    localparam logic [COORD_W-1:0] ONE     = COORD_W'(1);
    localparam logic [ADDR_W-1:0]  MAP_W_A = ADDR_W'(MAP_W);

    state_t state, next_state;

    logic [CSEL_W-1:0]  cap_sel;
    logic [1:0]         cap_dir;
    logic [2:0]         cap_sprite;
    logic [COORD_W-1:0] x0, y0;

    logic [COORD_W-1:0] tx, ty;
    logic               edge_reject;
    logic [ADDR_W-1:0]  tgt_addr, cur_addr;

    logic [ADDR_W-1:0]  n_address;
    logic               n_read, n_write, n_crw, n_done, n_blocked;
    logic [2:0]         n_data;
    logic [COORD_W-1:0] n_x_write, n_y_write;
    logic [CSEL_W-1:0]  n_sel_out;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
        return MAP_W_A * ADDR_W'(y) + ADDR_W'(x);
    endfunction

    // Request capture; the source inputs are free to change afterwards.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cap_sel    <= '0;
            cap_dir    <= '0;
            cap_sprite <= '0;
            x0         <= '0;
            y0         <= '0;
        end else if (state == IDLE && start) begin
            cap_sel    <= char_sel;
            cap_dir    <= dir;
            cap_sprite <= sprite_in;
            x0         <= x_read;
            y0         <= y_read;
        end
    end

    // Target tile. The captured operands are stable for the whole move, so the
    // target is derived combinationally; a rejected edge move leaves the target
    // at the current position so the read still hits a valid tile.
    always_comb begin
        tx          = x0;
        ty          = y0;
        edge_reject = 1'b0;
        case (cap_dir)
            2'b00: begin
                if (x0 == '0) begin
`ifdef CHAR_MOVER_WRAP_EN
                    tx = X_MAX;
`else
                    edge_reject = 1'b1;
`endif
                end else begin
                    tx = x0 - ONE;
                end
            end
            2'b01: begin
                if (x0 >= X_MAX) begin
`ifdef CHAR_MOVER_WRAP_EN
                    tx = '0;
`else
                    edge_reject = 1'b1;
`endif
                end else begin
                    tx = x0 + ONE;
                end
            end
            2'b10: begin
                if (y0 == '0) begin
`ifdef CHAR_MOVER_WRAP_EN
                    ty = Y_MAX;
`else
                    edge_reject = 1'b1;
`endif
                end else begin
                    ty = y0 - ONE;
                end
            end
            default: begin
                if (y0 >= Y_MAX) begin
`ifdef CHAR_MOVER_WRAP_EN
                    ty = '0;
`else
                    edge_reject = 1'b1;
`endif
                end else begin
                    ty = y0 + ONE;
                end
            end
        endcase
    end

    assign tgt_addr = tile_addr(tx, ty);
    assign cur_addr = tile_addr(x0, y0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    // Outputs are registered, so each state computes the values that must be
    // visible during the state it is entering.
    always_comb begin
        next_state = state;
        n_address  = '0;
        n_read     = 1'b0;
        n_write    = 1'b0;
        n_data     = '0;
        n_x_write  = x_write;
        n_y_write  = y_write;
        n_sel_out  = char_sel_out;
        n_crw      = 1'b0;
        n_done     = 1'b0;
        n_blocked  = blocked;
        case (state)
            IDLE: begin
                if (start) next_state = CALC;
            end
            CALC: begin
                next_state = RD;
                n_address  = tgt_addr;
                n_read     = 1'b1;
            end
            RD: begin
                next_state = CHK;
            end
            CHK: begin
                if (map_data_in == WALL_TILE || edge_reject) begin
                    next_state = FIN;
                    n_blocked  = 1'b1;
                    n_done     = 1'b1;
                end else begin
                    next_state = ERASE;
                    n_blocked  = 1'b0;
                    n_address  = cur_addr;
                    n_write    = 1'b1;
                end
            end
            ERASE: begin
                next_state = DRAW;
                n_address  = tgt_addr;
                n_data     = cap_sprite;
                n_write    = 1'b1;
            end
            DRAW: begin
                next_state = UPD;
                n_x_write  = tx;
                n_y_write  = ty;
                n_sel_out  = cap_sel;
                n_crw      = 1'b1;
            end
            UPD: begin
                next_state = FIN;
                n_done     = 1'b1;
            end
            FIN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            map_address    <= '0;
            map_read       <= 1'b0;
            map_write      <= 1'b0;
            map_data_out   <= '0;
            x_write        <= '0;
            y_write        <= '0;
            char_sel_out   <= '0;
            char_reg_write <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            blocked        <= 1'b0;
        end else begin
            map_address    <= n_address;
            map_read       <= n_read;
            map_write      <= n_write;
            map_data_out   <= n_data;
            x_write        <= n_x_write;
            y_write        <= n_y_write;
            char_sel_out   <= n_sel_out;
            char_reg_write <= n_crw;
            busy           <= (next_state != IDLE);
            done           <= n_done;
            blocked        <= n_blocked;
        end
    end

endmodule

// File: tb/tb_character_mover.sv
// tb_character_mover
//   Table of directed moves (including edge cases, with expectations chosen by
//   CHAR_MOVER_WRAP_EN), hand-written sequences for start-while-busy and
//   asynchronous reset mid-move, then random moves checked against a
//   tile-arithmetic model of the move rules.
module tb_character_mover;

    localparam int         MAP_W = 21;
    localparam int         MAP_H = 21;
    localparam logic [2:0] WALL  = 3'd1;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] char_sel;
    logic [1:0] dir;
    logic [2:0] sprite_in;
    logic [7:0] x_read, y_read;
    logic [2:0] map_data_in = '0;
    logic [8:0] map_address;
    logic       map_read, map_write;
    logic [2:0] map_data_out;
    logic [7:0] x_write, y_write;
    logic [1:0] char_sel_out;
    logic       char_reg_write, busy, done, blocked;

    character_mover #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .COORD_W(8), .ADDR_W(9),
        .NUM_CHARS(4), .WALL_TILE(WALL)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .char_sel(char_sel), .dir(dir), .sprite_in(sprite_in),
        .x_read(x_read), .y_read(y_read), .map_data_in(map_data_in),
        .map_address(map_address), .map_read(map_read), .map_write(map_write),
        .map_data_out(map_data_out), .x_write(x_write), .y_write(y_write),
        .char_sel_out(char_sel_out), .char_reg_write(char_reg_write),
        .busy(busy), .done(done), .blocked(blocked)
    );

    always #5 clock = ~clock;

    logic [2:0] mem [0:511];
    int rd_q[$];
    int wr_q[$];
    int cw_q[$];
    int done_cnt = 0;
    int clash    = 0;
    int n_chk    = 0;
    int n_fail   = 0;

    // Synchronous map memory plus a log of every strobe the DUT issues.
    always @(posedge clock) begin
        if (map_read) begin
            map_data_in <= mem[map_address];
            rd_q.push_back(int'(map_address));
        end
        if (map_write)
            wr_q.push_back(int'(map_address) * 8 + int'(map_data_out));
        if (char_reg_write)
            cw_q.push_back(int'(char_sel_out) * 65536 + int'(x_write) * 256 + int'(y_write));
        if (done) done_cnt++;
        if (int'(map_read) + int'(map_write) + int'(char_reg_write) + int'(done) > 1) clash++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // One complete move; expectations come from the tile rules applied to the
    // bench's own map copy.
    task automatic run_move(input int cs, input int x, input int y, input int d,
                            input int sp, input bit inject,
                            output int rd_seen, output int cw_seen, output int blk_seen);
        int nx, ny, rd, lat;
        bit rej, acc;
        nx  = x + ((d == 0) ? -1 : (d == 1) ? 1 : 0);
        ny  = y + ((d == 2) ? -1 : (d == 3) ? 1 : 0);
        rej = 1'b0;
`ifdef CHAR_MOVER_WRAP_EN
        nx = (nx + MAP_W) % MAP_W;
        ny = (ny + MAP_H) % MAP_H;
`else
        if (nx < 0 || nx >= MAP_W || ny < 0 || ny >= MAP_H) begin
            rej = 1'b1;
            nx  = x;
            ny  = y;
        end
`endif
        rd  = ny * MAP_W + nx;
        acc = !rej && (mem[rd] != WALL);

        @(negedge clock);
        rd_q.delete(); wr_q.delete(); cw_q.delete();
        done_cnt  = 0;
        char_sel  = 2'(cs);
        x_read    = 8'(x);
        y_read    = 8'(y);
        dir       = 2'(d);
        sprite_in = 3'(sp);
        start     = 1'b1;
        @(posedge clock);
        #1;
        start     = 1'b0;
        char_sel  = 2'($urandom);
        x_read    = 8'($urandom);
        y_read    = 8'($urandom);
        dir       = 2'($urandom);
        sprite_in = 3'($urandom);

        lat = 0;
        blk_seen = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (k == 1) chk("busy_after_start", int'(busy), 1);
            start = inject && (k == 4);
            if (done && lat == 0) begin
                lat = k;
                blk_seen = int'(blocked);
            end
        end
        start = 1'b0;

        chk("done_latency", lat, acc ? 7 : 4);
        chk("blocked", blk_seen, acc ? 0 : 1);
        chk("blocked_hold", int'(blocked), acc ? 0 : 1);
        chk("done_count", done_cnt, 1);
        chk("read_count", rd_q.size(), 1);
        rd_seen = (rd_q.size() > 0) ? rd_q[0] : -1;
        chk("read_addr", rd_seen, rd);
        chk("write_count", wr_q.size(), acc ? 2 : 0);
        if (acc && wr_q.size() == 2) begin
            chk("erase_write", wr_q[0], (y * MAP_W + x) * 8);
            chk("draw_write", wr_q[1], rd * 8 + sp);
        end
        chk("charreg_count", cw_q.size(), acc ? 1 : 0);
        cw_seen = (cw_q.size() > 0) ? cw_q[0] : -1;
        if (acc) chk("charreg_write", cw_seen, cs * 65536 + nx * 256 + ny);
    endtask

    typedef struct {
        int cs, x, y, d, sp;
        int blk, rd, xw, yw;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int rd_seen, cw_seen, blk_seen;

        tbl[0] = '{2, 5, 5, 1, 5, 0, 111, 6, 5};
        tbl[1] = '{0, 3, 4, 2, 3, 1, 66, 0, 0};
`ifdef CHAR_MOVER_WRAP_EN
        tbl[2] = '{1, 0, 7, 0, 4, 0, 167, 20, 7};
        tbl[3] = '{3, 10, 20, 3, 6, 0, 10, 10, 0};
        tbl[4] = '{1, 20, 3, 1, 2, 0, 63, 0, 3};
        tbl[5] = '{0, 4, 0, 2, 7, 0, 424, 4, 20};
`else
        tbl[2] = '{1, 0, 7, 0, 4, 1, 147, 0, 0};
        tbl[3] = '{3, 10, 20, 3, 6, 1, 430, 0, 0};
        tbl[4] = '{1, 20, 3, 1, 2, 1, 83, 0, 0};
        tbl[5] = '{0, 4, 0, 2, 7, 1, 4, 0, 0};
`endif

        for (int i = 0; i < 512; i++)
            mem[i] = ($urandom_range(0, 3) == 0) ? WALL : 3'($urandom_range(2, 7));
        mem[111] = 3'd0;
        mem[66]  = WALL;
        mem[167] = 3'd0;
        mem[10]  = 3'd2;
        mem[63]  = 3'd0;
        mem[424] = 3'd0;

        resetn = 1'b0; start = 1'b0; char_sel = '0; dir = '0;
        sprite_in = '0; x_read = '0; y_read = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_strobes", int'({busy, done, blocked, map_read, map_write, char_reg_write}), 0);
        chk("rst_addr", int'(map_address), 0);
        chk("rst_data", int'(map_data_out), 0);
        chk("rst_xy", int'({x_write, y_write}), 0);
        chk("rst_sel", int'(char_sel_out), 0);
        resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_move(tbl[i].cs, tbl[i].x, tbl[i].y, tbl[i].d, tbl[i].sp, 1'b0,
                     rd_seen, cw_seen, blk_seen);
            chk("tbl_blocked", blk_seen, tbl[i].blk);
            chk("tbl_read_addr", rd_seen, tbl[i].rd);
            if (tbl[i].blk == 0)
                chk("tbl_xy", cw_seen & 16'hFFFF, tbl[i].xw * 256 + tbl[i].yw);
        end

        // start pulsed during ERASE must be dropped, leaving a single done
        run_move(2, 5, 5, 1, 5, 1'b1, rd_seen, cw_seen, blk_seen);

        // asynchronous reset while in DRAW
        @(negedge clock);
        cw_q.delete();
        char_sel = 2'd2; x_read = 8'd5; y_read = 8'd5; dir = 2'd1; sprite_in = 3'd3;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(negedge clock);
        chk("draw_strobe", int'(map_write), 1);
        #1 resetn = 1'b0;
        #1;
        chk("arst_strobes", int'({busy, done, blocked, map_read, map_write, char_reg_write}), 0);
        chk("arst_addr", int'(map_address), 0);
        chk("arst_data", int'(map_data_out), 0);
        chk("arst_xy", int'({x_write, y_write}), 0);
        chk("arst_sel", int'(char_sel_out), 0);
        repeat (3) @(negedge clock);
        chk("arst_no_charreg", cw_q.size(), 0);
        resetn = 1'b1;
        run_move(1, 5, 5, 1, 4, 1'b0, rd_seen, cw_seen, blk_seen);

        for (int i = 0; i < 40; i++)
            run_move(int'($urandom_range(0, 3)), int'($urandom_range(0, MAP_W - 1)),
                     int'($urandom_range(0, MAP_H - 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                     rd_seen, cw_seen, blk_seen);

        chk("strobe_exclusive", clash, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
